// File: rtl/irq_prio_ctrl.sv
// Vectored fixed-priority interrupt controller with nesting via an in-service bitmap.
// Optional software trigger input enabled by defining IRQC_SW_TRIGGER_EN.
module irq_prio_ctrl #(
  parameter int          NUM_SRC     = 8,
  parameter logic [15:0] VEC_BASE    = 16'hFFC0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_SRC-1:0] i_irq_in_n,
  input  logic               i_mask_wr,
  input  logic [NUM_SRC-1:0] i_mask_in,
  input  logic               i_mode_wr,
  input  logic [NUM_SRC-1:0] i_mode_in,
  input  logic               i_int_ack,
  input  logic               i_int_eoi,
`ifdef IRQC_SW_TRIGGER_EN
  input  logic [NUM_SRC-1:0] i_sw_set,
`endif
  output logic               o_cpu_irq_n,
  output logic [15:0]        o_vec_out,
  output logic               o_vec_valid,
  output logic [NUM_SRC-1:0] o_isr_out,
  output logic [NUM_SRC-1:0] o_pend_out
);

  localparam int IW = $clog2(NUM_SRC + 1);

  logic [NUM_SRC-1:0] r_sync [SYNC_STAGES];
  logic [NUM_SRC-1:0] r_s_d;
  logic [NUM_SRC-1:0] r_pend;
  logic [NUM_SRC-1:0] r_isr;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_mode;
  logic               r_cpu_irq_n;
  logic [15:0]        r_vec;
  logic               r_vec_valid;

  logic [NUM_SRC-1:0] w_s;
  logic [NUM_SRC-1:0] w_fall;
  logic [NUM_SRC-1:0] w_req;
  logic [IW-1:0]      w_req_idx;
  logic [IW-1:0]      w_isr_idx;
  logic               w_elig;
  logic [IW-1:0]      w_vec_idx;
  logic [15:0]        w_vec;
  logic [NUM_SRC-1:0] w_ack_set;
  logic [NUM_SRC-1:0] w_eoi_clr;
  logic [NUM_SRC-1:0] w_mode_chg;
  logic [NUM_SRC-1:0] w_sw_set;
  logic [NUM_SRC-1:0] w_sw_hold_kept;
  logic [NUM_SRC-1:0] w_edge_nxt;
  logic [NUM_SRC-1:0] w_lvl_nxt;
  logic [NUM_SRC-1:0] w_pend_nxt;

  // Synchroniser and history flops reset high so releasing reset never looks like a falling edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int j = 0; j < SYNC_STAGES; j++) r_sync[j] <= '1;
      r_s_d <= '1;
    end else begin
      r_sync[0] <= i_irq_in_n;
      for (int j = 1; j < SYNC_STAGES; j++) r_sync[j] <= r_sync[j-1];
      r_s_d <= w_s;
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_fall = r_s_d & ~w_s;
  assign w_req  = r_pend & ~r_mask & ~r_isr;

  // Lowest set index wins; an empty vector encodes as NUM_SRC.
  always_comb begin
    w_req_idx = IW'(NUM_SRC);
    w_isr_idx = IW'(NUM_SRC);
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_req[i]) w_req_idx = IW'(i);
      if (r_isr[i]) w_isr_idx = IW'(i);
    end
  end

  assign w_elig    = (|w_req) && (w_req_idx < w_isr_idx);
  assign w_vec_idx = w_elig ? w_req_idx : IW'(NUM_SRC);
  assign w_vec     = VEC_BASE + {15'(w_vec_idx), 1'b0};

  always_comb begin
    w_ack_set = '0;
    w_eoi_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i_int_ack && w_elig && (w_req_idx == IW'(i))) w_ack_set[i] = 1'b1;
      if (i_int_eoi && (w_isr_idx == IW'(i)))           w_eoi_clr[i] = 1'b1;
    end
  end

  assign w_mode_chg = i_mode_wr ? (i_mode_in ^ r_mode) : '0;

`ifdef IRQC_SW_TRIGGER_EN
  logic [NUM_SRC-1:0] r_sw_hold;

  // Level-mode sources need a sticky copy of a software trigger until it is acknowledged.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sw_hold <= '0;
    else       r_sw_hold <= (w_sw_hold_kept | (i_sw_set & ~r_mode)) & ~w_mode_chg;
  end

  assign w_sw_set       = i_sw_set;
  assign w_sw_hold_kept = r_sw_hold & ~w_ack_set;
`else
  assign w_sw_set       = '0;
  assign w_sw_hold_kept = '0;
`endif

  assign w_edge_nxt = (r_pend & ~w_ack_set) | w_fall | w_sw_set;
  assign w_lvl_nxt  = ~w_s | w_sw_set | w_sw_hold_kept;
  assign w_pend_nxt = ((r_mode & w_edge_nxt) | (~r_mode & w_lvl_nxt)) & ~w_mode_chg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend      <= '0;
      r_isr       <= '0;
      r_mask      <= '1;
      r_mode      <= '0;
      r_cpu_irq_n <= 1'b1;
      r_vec       <= 16'h0000;
      r_vec_valid <= 1'b0;
    end else begin
      r_pend      <= w_pend_nxt;
      r_isr       <= (r_isr & ~w_eoi_clr) | w_ack_set;
      r_cpu_irq_n <= ~w_elig;
      r_vec_valid <= i_int_ack;
      if (i_int_ack) r_vec  <= w_vec;
      if (i_mask_wr) r_mask <= i_mask_in;
      if (i_mode_wr) r_mode <= i_mode_in;
    end
  end

  assign o_cpu_irq_n = r_cpu_irq_n;
  assign o_vec_out   = r_vec;
  assign o_vec_valid = r_vec_valid;
  assign o_isr_out   = r_isr;
  assign o_pend_out  = r_pend;

endmodule

// File: doc/irq_prio_ctrl.md
Name: irq_prio_ctrl

Overview:
- Parametrised, vectored, multi-source interrupt controller. Successor to the CPU's single-IRQ/NMI interrupt logic.
- Collects NUM_SRC active-low interrupt lines and applies per-source masking and edge/level mode.
- Resolves fixed priority with nesting, based on an in-service bitmap.
- Presents one active-low request to the CPU core and returns a 16-bit vector address on acknowledge.

Parameters:
- NUM_SRC, 8, number of interrupt sources; legal range 1..16; index 0 has the highest priority.
- VEC_BASE, 16'hFFC0, base vector address; source i vectors to VEC_BASE + 2*i.
- SYNC_STAGES, 2, input synchroniser depth; legal range 2..3.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- irq_in_n  in  NUM_SRC  raw interrupt lines, active low, asynchronous.
- mask_wr  in  1  load mask_in into the mask register.
- mask_in  in  NUM_SRC  1 = source masked.
- mode_wr  in  1  load mode_in into the mode register.
- mode_in  in  NUM_SRC  1 = falling-edge triggered, 0 = level (low) triggered.
- int_ack  in  1  one-cycle pulse from the CPU when it starts the vector fetch.
- int_eoi  in  1  one-cycle end-of-interrupt pulse.
- cpu_irq_n  out  1  registered combined request to the CPU, active low.
- vec_out  out  16  registered vector address.
- vec_valid  out  1  one-cycle pulse; vec_out is valid.
- isr_out  out  NUM_SRC  in-service bitmap, for debug.
- pend_out  out  NUM_SRC  pending bitmap, for debug.

Behaviour:
- Reset (async, rst=1):
  - mask = all 1s; mode = all 0s.
  - pending = 0; ISR = 0.
  - synchroniser flops and the edge-history flop = all 1s, so there is no false edge on release.
  - cpu_irq_n = 1; vec_out = 16'h0000; vec_valid = 0.
  - Reset asserted mid-handshake discards all state; no vec_valid is emitted.
- Synchroniser: irq_in_n passes through SYNC_STAGES flops to give s. A history flop s_d = s delayed one clock.
- Pending:
  - Edge mode: pending[i] sets when s_d[i]=1 and s[i]=0, and holds until acknowledged.
  - Level mode: pending[i] = ~s[i] on every clock (registered); it is never latched.
- Eligibility:
  - req = pending & ~mask & ~ISR.
  - eligible = the lowest set index of req, but only if that index is strictly less than the lowest set ISR index (an empty ISR allows all).
- Outputs:
  - cpu_irq_n is registered: cpu_irq_n <= ~(eligible exists).
  - Latency with SYNC_STAGES=2: line falls before edge 1 → s low at edge 2 → pending at edge 3 → cpu_irq_n low at edge 4.
- Acknowledge (int_ack=1), evaluated on the pre-edge state:
  - Eligible source k exists: ISR[k] set; pending[k] cleared if k is edge mode; vec_out <= VEC_BASE + {k,1'b0}; vec_valid <= 1 next cycle.
  - No eligible source (spurious): vec_out <= VEC_BASE + 2*NUM_SRC; ISR and pending unchanged; vec_valid still pulses.
  - cpu_irq_n is re-evaluated from the post-ack state, so it deasserts one edge after the ack unless a higher-priority source is eligible.
- End of interrupt (int_eoi=1):
  - Clears the lowest set ISR bit (the highest priority in service).
  - ISR empty: no effect.
- Simultaneous events:
  - New edge on source k in the same cycle as the ack of k: pending[k] remains set (set wins).
  - ack + eoi in the same cycle: both use pre-edge state; eoi clears its bit and ack sets its bit. If they target the same bit, the set wins.
  - mask_wr or mode_wr in the same cycle as ack: ack uses the old mask/mode. New values take effect the next cycle.
  - Mode change: pending[i] is cleared on the mode_wr edge for every bit whose mode changes.
- Arithmetic:
  - Vector computation is 16-bit, wrap-around modulo 2^16.
  - Index width = clog2(NUM_SRC+1).

Optional Feature:
- Macro: IRQC_SW_TRIGGER_EN.
- When defined:
  - Adds input sw_set (NUM_SRC bits).
  - Each 1 bit sets pending[i] on the next edge regardless of mode. For level-mode bits, the flag is held until acknowledged.
  - sw_set has priority over the edge-mode ack-clear.
- When undefined: the port is absent and pending is driven only by irq_in_n.

Test Plan:
- Reset release, all lines high, mask=0, mode=all edge → cpu_irq_n stays 1 for 20 cycles; pend_out=0; isr_out=0.
- mode=all edge, mask=0, irq_in_n[3] falls → cpu_irq_n=0 exactly 4 edges later; int_ack → vec_out=16'hFFC6, vec_valid for 1 cycle, isr_out=8'h08, cpu_irq_n=1.
- Source 5 in service, then irq_in_n[1] falls → cpu_irq_n=0 (nesting); ack → vec_out=16'hFFC2, isr_out=8'h22; int_eoi → isr_out=8'h20; second int_eoi → 8'h00.
- Sources 2 and 6 pending simultaneously, mask[2]=1 → ack yields 16'hFFCC; then mask_wr clears mask[2] → 16'hFFC4 is delivered next, preempting 6.
- Level-mode source 0 held low, ack then eoi → cpu_irq_n reasserts; release line before ack → ack gives spurious vector 16'hFFD0 and isr_out unchanged.
- Assert rst mid-ack (cycle after int_ack) → vec_valid never pulses; all outputs return to reset values asynchronously.
